// File: rtl/alu_rr_sequencer_pkg.sv
// Shared types for the round-robin ALU sequencer: op codes, FSM states
// and a small helper for one-hot client strobes.
package alu_seq_pkg;

  localparam int FUNC_W = 3;

  typedef enum logic [FUNC_W-1:0] {
    FN_ADDR  = 3'd0,  // ripple-carry add
    FN_ADD   = 3'd1,  // behavioural add, same result as FN_ADDR
    FN_ORXOR = 3'd2,  // {A|B, A^B}
    FN_ANY   = 3'd3,  // acc=1 when any bit of A|B is set
    FN_ALL   = 3'd4,  // acc=1 when A&B is all ones
    FN_SHR   = 3'd5,  // B >> A
    FN_SHL   = 3'd6,  // B << A
    FN_MUL   = 3'd7   // multi-cycle shift-add multiply
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Client index to its one-hot gnt/done strobe.
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// Client-side bundle of the ALU sequencer: two request/operand lanes in,
// grant/done strobes plus the accumulator view out.
interface alu_rr_sequencer_if #(
  parameter int DATA_W = 4
);
  import alu_seq_pkg::*;

  logic [1:0]          req;
  logic [FUNC_W-1:0]   func0;
  logic [DATA_W-1:0]   a0;
  logic [FUNC_W-1:0]   func1;
  logic [DATA_W-1:0]   a1;
  logic [1:0]          gnt;
  logic [1:0]          done;
  logic [2*DATA_W-1:0] result;
  logic                busy;
  logic [2*DATA_W-1:0] acc;

  // Clients drive requests and operands.
  modport master (
    output req, func0, a0, func1, a1,
    input  gnt, done, result, busy, acc
  );

  // The sequencer answers with strobes and the accumulator.
  modport slave (
    input  req, func0, a0, func1, a1,
    output gnt, done, result, busy, acc
  );

endinterface

// File: rtl/alu_rr_sequencer_alu_func_unit.sv
// Combinational single-cycle ALU ops (everything except multiply).
// o_we is low when the op decides to leave the accumulator unchanged.
module alu_func_unit
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  func_e               i_func,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic [2*DATA_W-1:0] o_result,
  output logic                o_we
);

  localparam int ACC_W = 2 * DATA_W;

  logic [DATA_W:0]   w_carry;
  logic [DATA_W-1:0] w_sum;
  logic [ACC_W-1:0]  w_a_ext;
  logic [ACC_W-1:0]  w_b_ext;

  assign w_a_ext    = {{DATA_W{1'b0}}, i_a};
  assign w_b_ext    = {{DATA_W{1'b0}}, i_b};
  assign w_carry[0] = 1'b0;

  // Explicit full-adder chain; the final carry lands in bit DATA_W.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ripple
    assign w_sum[gi]     = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
    assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
  end

  // Op decode: pick the result and decide whether acc gets written.
  always_comb begin
    o_result = '0;
    o_we     = 1'b0;
    case (i_func)
      FN_ADDR: begin
        o_result = {{(DATA_W-1){1'b0}}, w_carry[DATA_W], w_sum};
        o_we     = 1'b1;
      end
      FN_ADD: begin
        o_result = w_a_ext + w_b_ext;
        o_we     = 1'b1;
      end
      FN_ORXOR: begin
        o_result = {i_a | i_b, i_a ^ i_b};
        o_we     = 1'b1;
      end
      FN_ANY: begin
        if (|(i_a | i_b)) begin
          o_result = ACC_W'(1);
          o_we     = 1'b1;
        end
      end
      FN_ALL: begin
        if (&(i_a & i_b)) begin
          o_result = ACC_W'(1);
          o_we     = 1'b1;
        end
      end
      FN_SHR: begin
        o_we = 1'b1;
        if (w_a_ext >= ACC_W'(DATA_W)) o_result = '0;
        else                           o_result = w_b_ext >> i_a;
      end
      FN_SHL: begin
        o_we = 1'b1;
        if (w_a_ext >= ACC_W'(ACC_W)) o_result = '0;
        else                          o_result = w_b_ext << i_a;
      end
      default: begin
        // Multiply is sequenced by the top; nothing to write here.
        o_result = '0;
        o_we     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one accumulator ALU between two clients.
// IDLE arbitrates and latches the winning op, EXEC/MUL compute into acc,
// DONE strobes the owning client. All outputs come straight from registers.
module alu_rr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic          clock,
  input  logic          reset,
  alu_rr_sequencer_if.slave bus
);

  localparam int ACC_W = 2 * DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e            r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_prod;
  logic [1:0]        r_gnt;
  logic [1:0]        r_done;
  logic              r_busy;
  logic              r_rr_last;
  logic              r_id;
  func_e             r_func;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_win_id;
  func_e             w_win_func;
  logic [DATA_W-1:0] w_win_a;
  logic [ACC_W-1:0]  w_fu_result;
  logic              w_fu_we;
  logic [ACC_W-1:0]  w_b_ext;
  logic [ACC_W-1:0]  w_prod_next;

  // Winner: a lone requester wins outright; on a tie the client that did not
  // win last time goes first, so continuous requesters alternate.
  always_comb begin
    w_win_id = 1'b0;
    case (bus.req)
      2'b10:   w_win_id = 1'b1;
      2'b11:   w_win_id = ~r_rr_last;
      default: w_win_id = 1'b0;
    endcase
  end

  assign w_win_func = w_win_id ? func_e'(bus.func1) : func_e'(bus.func0);
  assign w_win_a    = w_win_id ? bus.a1 : bus.a0;

  // B is a snapshot of acc[DATA_W-1:0] taken at grant, so intermediate
  // writes during a multiply cannot disturb the multiplicand.
  assign w_b_ext     = {{DATA_W{1'b0}}, r_b};
  assign w_prod_next = r_prod + (r_a[r_cnt] ? (w_b_ext << r_cnt) : '0);

  alu_func_unit #(
    .DATA_W (DATA_W)
  ) u_func_unit (
    .i_func   (r_func),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_fu_result),
    .o_we     (w_fu_we)
  );

  // Sequencer FSM with registered strobes, accumulator and multiply state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_prod    <= '0;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_busy    <= 1'b0;
      r_rr_last <= 1'b1;
      r_id      <= 1'b0;
      r_func    <= FN_ADDR;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
    end else begin
      r_gnt  <= 2'b00;
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            r_id      <= w_win_id;
            r_func    <= w_win_func;
            r_a       <= w_win_a;
            r_b       <= r_acc[DATA_W-1:0];
            r_cnt     <= '0;
            r_prod    <= '0;
            r_rr_last <= w_win_id;
            r_gnt     <= id_onehot(w_win_id);
            r_busy    <= 1'b1;
            r_state   <= (w_win_func == FN_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_fu_we) r_acc <= w_fu_result;
          r_done  <= id_onehot(r_id);
          r_state <= S_DONE;
        end
        S_MUL: begin
          r_prod <= w_prod_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_acc   <= w_prod_next;
            r_done  <= id_onehot(r_id);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.acc    = r_acc;
  assign bus.result = r_acc;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer: hand-computed accumulator values,
// grant/done timing, round-robin order and reset abort.
module tb_alu_rr_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  alu_rr_sequencer_if #(.DATA_W(4)) bus ();

  alu_rr_sequencer #(
    .DATA_W (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] g_seq   [4];
  logic [1:0] d_seq   [4];
  logic [7:0] acc_seq [4];
  int ng, nd, cyc, cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One op from a single client; done comes 1 edge after the grant for
  // single-cycle ops and 4 edges after it for multiply.
  task automatic run_op(input int client, input logic [2:0] func, input logic [3:0] a,
                        input logic [7:0] exp_acc, input string tag);
    int lat;
    logic [1:0] exp_oh;
    exp_oh = (client == 1) ? 2'b10 : 2'b01;
    if (client == 1) begin
      bus.func1 = func;
      bus.a1    = a;
    end else begin
      bus.func0 = func;
      bus.a0    = a;
    end
    bus.req = exp_oh;
    tick();
    check({tag, ".gnt"}, bus.gnt, exp_oh);
    bus.req = 2'b00;
    lat = 0;
    while (bus.done == 2'b00 && lat < 20) begin
      check({tag, ".busy"}, bus.busy, 1);
      tick();
      lat++;
    end
    check({tag, ".lat"}, lat, (func == 3'd7) ? 4 : 1);
    check({tag, ".done"}, bus.done, exp_oh);
    check({tag, ".gnt_off"}, bus.gnt, 2'b00);
    check({tag, ".acc"}, bus.acc, exp_acc);
    check({tag, ".result"}, bus.result, exp_acc);
    $display("op %s: client=%0d func=%0d a=0x%0h -> acc=0x%02h after %0d cycles",
             tag, client, func, a, bus.acc, lat);
    tick();
    check({tag, ".idle"}, bus.busy, 0);
  endtask

  // Load a small value into acc: reset, then 0 + v.
  task automatic set_acc(input logic [3:0] v);
    do_reset();
    run_op(0, 3'd0, v, {4'h0, v}, "preset");
  endtask

  initial begin
    bus.req   = 2'b00;
    bus.func0 = 3'd0;
    bus.a0    = 4'h0;
    bus.func1 = 3'd0;
    bus.a1    = 4'h0;

    // Reset state
    tick();
    tick();
    check("rst.acc", bus.acc, 0);
    check("rst.gnt", bus.gnt, 0);
    check("rst.done", bus.done, 0);
    check("rst.busy", bus.busy, 0);
    reset = 1'b0;

    // 1: ripple add, then add with carry into bit 4
    run_op(0, 3'd0, 4'h5, 8'h05, "t1.add");
    run_op(0, 3'd0, 4'hF, 8'h14, "t1.add_carry");

    // 2: multiply 0xB * 0xA
    set_acc(4'hA);
    run_op(1, 3'd7, 4'hB, 8'h6E, "t2.mul");

    // 3: both clients request continuously
    do_reset();
    bus.func0 = 3'd1; bus.a0 = 4'h1;
    bus.func1 = 3'd1; bus.a1 = 4'h1;
    bus.req   = 2'b11;
    ng = 0; nd = 0; cyc = 0;
    while (nd < 4 && cyc < 60) begin
      tick();
      cyc++;
      check("t3.excl", (bus.gnt != 2'b00) && (bus.done != 2'b00), 0);
      if (bus.gnt != 2'b00 && ng < 4) begin
        g_seq[ng] = bus.gnt;
        ng++;
      end
      if (bus.done != 2'b00) begin
        d_seq[nd]   = bus.done;
        acc_seq[nd] = bus.acc;
        nd++;
      end
    end
    bus.req = 2'b00;
    check("t3.ndone", nd, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3.gnt%0d", i), g_seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("t3.done%0d", i), d_seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("t3.acc%0d", i), acc_seq[i], i + 1);
      $display("rr op %0d: gnt=%b done=%b acc=0x%02h", i, g_seq[i], d_seq[i], acc_seq[i]);
    end
    tick();
    tick();

    // 4: or/xor, any, all, behavioural add
    set_acc(4'h6);
    run_op(1, 3'd2, 4'h3, 8'h75, "t4.orxor");
    do_reset();
    run_op(0, 3'd3, 4'h0, 8'h00, "t4.any_zero");
    set_acc(4'h8);
    run_op(0, 3'd0, 4'h8, 8'h10, "t4.pre10");
    run_op(1, 3'd3, 4'h0, 8'h10, "t4.any_hold");
    set_acc(4'hE);
    run_op(0, 3'd3, 4'h0, 8'h01, "t4.any_set");
    set_acc(4'hF);
    run_op(1, 3'd4, 4'hF, 8'h01, "t4.all_set");
    set_acc(4'hE);
    run_op(0, 3'd4, 4'hF, 8'h0E, "t4.all_hold");
    set_acc(4'h9);
    run_op(1, 3'd1, 4'h9, 8'h12, "t4.add_beh");

    // 5: shifts and their out-of-range limits
    set_acc(4'h8);
    run_op(0, 3'd5, 4'h3, 8'h01, "t5.shr3");
    set_acc(4'hF);
    run_op(0, 3'd5, 4'h4, 8'h00, "t5.shr4");
    set_acc(4'h1);
    run_op(0, 3'd5, 4'h9, 8'h00, "t5.shr9");
    set_acc(4'h3);
    run_op(1, 3'd6, 4'h6, 8'hC0, "t5.shl6");
    set_acc(4'h3);
    run_op(1, 3'd6, 4'h7, 8'h80, "t5.shl7");
    set_acc(4'h3);
    run_op(1, 3'd6, 4'h8, 8'h00, "t5.shl8");

    // Withdrawn request: client 1 raises req while busy, drops it before IDLE
    set_acc(4'h2);
    bus.func0 = 3'd1; bus.a0 = 4'h1;
    bus.req   = 2'b01;
    tick();
    check("drop.gnt0", bus.gnt, 2'b01);
    bus.req = 2'b10;
    tick();
    check("drop.done0", bus.done, 2'b01);
    check("drop.acc", bus.acc, 8'h03);
    bus.req = 2'b00;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.gnt != 2'b00) cnt++;
    end
    check("drop.no_gnt", cnt, 0);
    $display("withdrawn request: grants seen=%0d", cnt);

    // 6: reset during the second MUL cycle aborts the op
    set_acc(4'hA);
    bus.func1 = 3'd7; bus.a1 = 4'hB;
    bus.req   = 2'b10;
    tick();
    check("t6.gnt", bus.gnt, 2'b10);
    bus.req = 2'b00;
    tick();
    check("t6.busy_mul2", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done != 2'b00) cnt++;
      tick();
    end
    check("t6.no_done", cnt, 0);
    check("t6.acc", bus.acc, 0);
    check("t6.busy", bus.busy, 0);
    bus.func0 = 3'd1; bus.a0 = 4'h1;
    bus.func1 = 3'd1; bus.a1 = 4'h1;
    bus.req   = 2'b11;
    tick();
    check("t6.tie_gnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    cyc = 0;
    while (bus.done == 2'b00 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("t6.done", bus.done, 2'b01);
    check("t6.acc_after", bus.acc, 8'h01);
    $display("reset abort: dones during abort=%0d, tie grant after reset, acc=0x%02h", cnt, bus.acc);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit expired");
    $fatal(1);
  end

endmodule
